// File: rtl/regfile_wr_sched_pkg.sv
// Shared constants and state encoding for the register-file write scheduler.
package regfile_pkg;
  localparam int RF_DW   = 32;
  localparam int RF_AW   = 3;
  localparam int RF_NREG = 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/regfile_wr_sched_if.sv
// Two write requesters sharing the register-file write port via valid/ready.
interface regfile_wr_sched_if;
  import regfile_pkg::*;

  logic              req0_valid;
  logic [RF_AW-1:0]  req0_addr;
  logic [RF_DW-1:0]  req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [RF_AW-1:0]  req1_addr;
  logic [RF_DW-1:0]  req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       cr,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic last_gnt;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: flops use non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr)      last_gnt <= 1'b1;
    else if (upd) last_gnt <= gnt[1];
  end
endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: zero-fill sequencer plus round-robin sharing.
module regfile_wr_sched
  import regfile_pkg::*;
#(
  parameter int DW      = RF_DW,
  parameter int AW      = RF_AW,
  parameter int NREG    = RF_NREG,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 cr,
  input  logic                 init_req,
  output logic                 init_busy,
  regfile_wr_sched_if.slave    rq,
  output logic                 WE,
  output logic [AW-1:0]        Addr_W,
  output logic [DW-1:0]        Di,
  output logic [15:0]          stall_cnt
);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic [1:0]    req, gnt;
  logic          en, hs, contend;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign req     = {rq.req1_valid, rq.req0_valid};
  assign en      = (state == ST_RUN) && !init_req;
  assign hs      = |(req & gnt);
  assign contend = en && rq.req0_valid && rq.req1_valid;

  rr_arb2 u_arb (
    .clk (clk),
    .cr  (cr),
    .req (req),
    .en  (en),
    .upd (hs),
    .gnt (gnt)
  );

  assign rq.req0_ready = gnt[0];
  assign rq.req1_ready = gnt[1];
  assign init_busy     = (state == ST_INIT);
  assign sel_addr      = gnt[1] ? rq.req1_addr : rq.req0_addr;
  assign sel_data      = gnt[1] ? rq.req1_data : rq.req0_data;

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state  <= ST_INIT;
      cnt    <= '0;
      WE     <= 1'b0;
      Addr_W <= '0;
      Di     <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          // Zero-fill writes ignore R0_ZERO so register 0 is cleared too.
          WE     <= 1'b1;
          Addr_W <= cnt;
          Di     <= '0;
          if (cnt == LAST_IDX) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
            WE    <= 1'b0;
          end else if (hs) begin
            WE     <= !(R0_ZERO && (sel_addr == '0));
            Addr_W <= sel_addr;
            Di     <= sel_data;
          end else begin
            WE <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr)                                    stall_cnt <= '0;
    else if (contend && stall_cnt != 16'hFFFF)  stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench: queue-based reference model compared every cycle plus directed literal checks.
module tb_regfile_wr_sched;
  import regfile_pkg::*;

  localparam bit R0Z = 1'b1;

  logic        clk = 1'b0;
  logic        cr = 1'b0;
  logic        init_req = 1'b0;
  logic        init_busy, WE;
  logic [2:0]  Addr_W;
  logic [31:0] Di;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wr_sched_if rq ();

  regfile_wr_sched #(.R0_ZERO(R0Z)) dut (
    .clk       (clk),
    .cr        (cr),
    .init_req  (init_req),
    .init_busy (init_busy),
    .rq        (rq),
    .WE        (WE),
    .Addr_W    (Addr_W),
    .Di        (Di),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending zero-fill addresses kept as a queue; busy while it is non-empty.
  int          m_fill[$];
  int          m_last;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_di;
  int          m_stall;

  function automatic void load_fill();
    m_fill.delete();
    for (int i = 0; i < RF_NREG; i++) m_fill.push_back(i);
  endfunction

  function automatic void pred_ready(output bit r0, output bit r1);
    bit v0, v1;
    v0 = (rq.req0_valid === 1'b1);
    v1 = (rq.req1_valid === 1'b1);
    r0 = 1'b0;
    r1 = 1'b0;
    if (m_fill.size() == 0 && init_req !== 1'b1) begin
      if (v0 && v1) begin
        if (m_last == 1) r0 = 1'b1;
        else             r1 = 1'b1;
      end else begin
        r0 = v0;
        r1 = v1;
      end
    end
  endfunction

  initial begin
    forever begin
      bit r0, r1, busy;
      @(posedge clk or negedge cr);
      if (!cr) begin
        load_fill();
        m_last  = 1;
        m_we    = 1'b0;
        m_addr  = 0;
        m_di    = '0;
        m_stall = 0;
      end else begin
        pred_ready(r0, r1);
        busy = (m_fill.size() != 0);
        if (!busy && rq.req0_valid && rq.req1_valid && !init_req && m_stall < 65535)
          m_stall++;
        if (busy) begin
          m_we   = 1'b1;
          m_addr = m_fill.pop_front();
          m_di   = '0;
        end else if (init_req) begin
          load_fill();
          m_we = 1'b0;
        end else if (r0 || r1) begin
          m_last = r1 ? 1 : 0;
          m_addr = r1 ? int'(rq.req1_addr) : int'(rq.req0_addr);
          m_di   = r1 ? rq.req1_data : rq.req0_data;
          m_we   = !(R0Z && m_addr == 0);
        end else begin
          m_we = 1'b0;
        end
      end
    end
  end

  // Compare on the falling edge, well away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      bit r0, r1;
      @(negedge clk);
      pred_ready(r0, r1);
      check("m_ready0", 64'(rq.req0_ready), 64'(r0));
      check("m_ready1", 64'(rq.req1_ready), 64'(r1));
      check("m_we",     64'(WE),            64'(m_we));
      check("m_addr",   64'(Addr_W),        64'(m_addr));
      check("m_di",     64'(Di),            64'(m_di));
      check("m_busy",   64'(init_busy),     64'(m_fill.size() != 0));
      check("m_stall",  64'(stall_cnt),     64'(m_stall));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rq.req0_valid = 1'b0; rq.req0_addr = '0; rq.req0_data = '0;
    rq.req1_valid = 1'b0; rq.req1_addr = '0; rq.req1_data = '0;

    // Reset state
    repeat (2) step();
    check("rst_we",    64'(WE),            64'(0));
    check("rst_busy",  64'(init_busy),     64'(1));
    check("rst_stall", 64'(stall_cnt),     64'(0));
    check("rst_rdy0",  64'(rq.req0_ready), 64'(0));

    // Zero-fill after release: edges 1..8 write 0..7, busy falls after edge 8
    cr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("fill_we",   64'(WE),        64'(1));
      check("fill_addr", 64'(Addr_W),    64'(i));
      check("fill_di",   64'(Di),        64'(0));
      check("fill_busy", 64'(init_busy), 64'(i < 7));
    end

    // Contention: both valid for 4 cycles, grants alternate 0,1,0,1
    rq.req0_valid = 1'b1; rq.req0_addr = 3'd1; rq.req0_data = 32'h11;
    rq.req1_valid = 1'b1; rq.req1_addr = 3'd2; rq.req1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_rdy0", 64'(rq.req0_ready), 64'(k % 2 == 0));
      check("tie_rdy1", 64'(rq.req1_ready), 64'(k % 2 == 1));
      step();
      check("tie_we",   64'(WE),     64'(1));
      check("tie_addr", 64'(Addr_W), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("tie_di",   64'(Di),     (k % 2 == 0) ? 64'h11 : 64'h22);
    end
    rq.req0_valid = 1'b0; rq.req1_valid = 1'b0;
    check("tie_stall", 64'(stall_cnt), 64'(4));

    // Single write, 1-cycle latency
    rq.req0_valid = 1'b1; rq.req0_addr = 3'd3; rq.req0_data = 32'hDEADBEEF;
    #1;
    check("w_rdy0", 64'(rq.req0_ready), 64'(1));
    check("w_rdy1", 64'(rq.req1_ready), 64'(0));
    step();
    rq.req0_valid = 1'b0;
    check("w_we",   64'(WE),     64'(1));
    check("w_addr", 64'(Addr_W), 64'(3));
    check("w_di",   64'(Di),     64'hDEADBEEF);
    step();
    check("w_we_off", 64'(WE),     64'(0));
    check("w_hold_a", 64'(Addr_W), 64'(3));
    check("w_hold_d", 64'(Di),     64'hDEADBEEF);

    // Write to r0 completes handshake but keeps WE low
    rq.req1_valid = 1'b1; rq.req1_addr = 3'd0; rq.req1_data = 32'hFFFFFFFF;
    #1;
    check("r0_rdy1", 64'(rq.req1_ready), 64'(1));
    step();
    rq.req1_valid = 1'b0;
    check("r0_we",   64'(WE),     64'(0));
    check("r0_addr", 64'(Addr_W), 64'(0));
    check("r0_di",   64'(Di),     64'hFFFFFFFF);

    // init_req pre-empts a pending request, which is granted once the fill ends
    init_req = 1'b1;
    rq.req0_valid = 1'b1; rq.req0_addr = 3'd5; rq.req0_data = 32'hA5;
    #1;
    check("ir_rdy0", 64'(rq.req0_ready), 64'(0));
    step();
    init_req = 1'b0;
    check("ir_we",   64'(WE),        64'(0));
    check("ir_busy", 64'(init_busy), 64'(1));
    for (int i = 0; i < 8; i++) begin
      #1;
      check("ir_fill_rdy0", 64'(rq.req0_ready), 64'(0));
      step();
      check("ir_fill_we",   64'(WE),     64'(1));
      check("ir_fill_addr", 64'(Addr_W), 64'(i));
      check("ir_fill_di",   64'(Di),     64'(0));
    end
    #1;
    check("ir_late_rdy0", 64'(rq.req0_ready), 64'(1));
    step();
    rq.req0_valid = 1'b0;
    check("ir_late_we",   64'(WE),     64'(1));
    check("ir_late_addr", 64'(Addr_W), 64'(5));
    check("ir_late_di",   64'(Di),     64'hA5);

    // Reset in the middle of a fill, then restart from address 0
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    repeat (6) step();
    check("mr_addr5", 64'(Addr_W), 64'(5));
    #2;
    cr = 1'b0;
    #1;
    check("mr_we",    64'(WE),            64'(0));
    check("mr_addr",  64'(Addr_W),        64'(0));
    check("mr_di",    64'(Di),            64'(0));
    check("mr_busy",  64'(init_busy),     64'(1));
    check("mr_stall", 64'(stall_cnt),     64'(0));
    check("mr_rdy1",  64'(rq.req1_ready), 64'(0));
    step();
    cr = 1'b1;
    step();
    check("mr_re_we",   64'(WE),     64'(1));
    check("mr_re_addr", 64'(Addr_W), 64'(0));
    repeat (9) step();
    check("end_we",   64'(WE),        64'(0));
    check("end_busy", 64'(init_busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
